// File: rtl/voting_machine_multi.sv
`default_nettype none
// ============================================================================
// Module      : voting_machine_multi
// Description : Parametrised ballot unit. Debounced one-vote-per-press
//               qualification, saturating per-candidate tallies, multi-press
//               rejection, result display and registered winner/tie tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module voting_machine_multi #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              mode,
    input  logic [NUM_CAND-1:0]               button,
    output logic [CNT_W-1:0]                  led,
    output logic                              vote_valid,
    output logic                              vote_invalid,
    output logic                              sat,
    output logic [$clog2(NUM_CAND)-1:0]       winner,
    output logic                              tie,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0] total
);

    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int HC_W  = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    cand_nxt;
    logic [HC_W-1:0]     hold_cnt;
    logic [HC_W-1:0]     hold_cnt_nxt;
    logic [CNT_W-1:0]    tally [NUM_CAND];

    logic                any_press;
    logic                multi_press;
    logic                one_hot;
    logic [IDX_W-1:0]    low_idx;
    logic [NUM_CAND-1:0] cand_mask;

    logic                do_vote;
    logic                do_invalid;
    logic [IDX_W-1:0]    vote_idx;

    logic [CNT_W-1:0]    max_val;
    logic [IDX_W-1:0]    best_idx;
    logic                dup_max;

    // Decode the raw button vector: any/multi/one-hot and lowest pressed index
    always_comb begin
        any_press   = |button;
        // clearing the lowest set bit leaves something only if >=2 bits are set
        multi_press = |(button & (button - NUM_CAND'(1)));
        one_hot     = any_press & ~multi_press;
        low_idx     = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (button[i]) begin
                low_idx = IDX_W'(i);
            end
        end
        cand_mask = NUM_CAND'(1) << cand;
    end

    // Press-qualification FSM: next state, hold counter and vote/reject strobes
    always_comb begin
        state_nxt    = state;
        cand_nxt     = cand;
        hold_cnt_nxt = hold_cnt;
        do_vote      = 1'b0;
        do_invalid   = 1'b0;
        vote_idx     = cand;
        case (state)
            IDLE: begin
                if (!mode) begin
                    if (one_hot) begin
                        cand_nxt = low_idx;
                        if (HOLD_CYCLES == 1) begin
                            // single-cycle qualification: the capture cycle is the vote
                            do_vote   = 1'b1;
                            vote_idx  = low_idx;
                            state_nxt = WAIT_REL;
                        end else begin
                            hold_cnt_nxt = HC_W'(1);
                            state_nxt    = HOLD;
                        end
                    end else if (multi_press) begin
                        do_invalid = 1'b1;
                        state_nxt  = WAIT_REL;
                    end
                end
            end
            HOLD: begin
                if (!mode && (button == cand_mask)) begin
                    if (hold_cnt == HC_W'(HOLD_CYCLES - 1)) begin
                        do_vote   = 1'b1;
                        state_nxt = WAIT_REL;
                    end else begin
                        hold_cnt_nxt = hold_cnt + 1'b1;
                    end
                end else begin
                    // press disturbed: no vote; extra buttons are flagged as a bad press
                    do_invalid = !mode && multi_press;
                    state_nxt  = any_press ? WAIT_REL : IDLE;
                end
            end
            WAIT_REL: begin
                if (!any_press) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cand     <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cand     <= cand_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Saturating tallies, running total, sticky saturation flag and event pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                tally[i] <= '0;
            end
            total        <= '0;
            vote_valid   <= 1'b0;
            vote_invalid <= 1'b0;
            sat          <= 1'b0;
        end else begin
            vote_valid   <= 1'b0;
            vote_invalid <= do_invalid;
            if (do_vote) begin
                if (tally[vote_idx] != {CNT_W{1'b1}}) begin
                    tally[vote_idx] <= tally[vote_idx] + 1'b1;
                    total           <= total + 1'b1;
                    vote_valid      <= 1'b1;
                end else begin
                    sat <= 1'b1;
                end
            end
        end
    end

    // Leader search: strict '>' keeps the lowest index on equal tallies
    always_comb begin
        max_val  = '0;
        best_idx = '0;
        dup_max  = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (tally[i] > max_val) begin
                max_val  = tally[i];
                best_idx = IDX_W'(i);
                dup_max  = 1'b0;
            end else if ((tally[i] == max_val) && (max_val != '0)) begin
                dup_max = 1'b1;
            end
        end
    end

    // Registered winner/tie, one cycle behind the tallies
    always_ff @(posedge clk) begin
        if (!rst) begin
            winner <= '0;
            tie    <= 1'b0;
        end else begin
            winner <= best_idx;
            tie    <= dup_max;
        end
    end

    // Display: tally of lowest pressed button in result mode, held when released
    always_ff @(posedge clk) begin
        if (!rst) begin
            led <= '0;
        end else if (!mode) begin
            led <= '0;
        end else if (any_press) begin
            led <= tally[low_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voting_machine_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_voting_machine_multi
// Description : Directed + randomised bench for voting_machine_multi. Two
//               instances (8-bit and 2-bit tallies) share all inputs and are
//               compared against a press-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voting_machine_multi;

    localparam int NC   = 4;
    localparam int HOLD = 10;
    localparam int MAXA = 255;
    localparam int MAXB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] button = '0;

    logic [7:0] led_a;
    logic       vv_a, vi_a, sat_a, tie_a;
    logic [1:0] winner_a;
    logic [9:0] total_a;
    logic [1:0] led_b;
    logic       vv_b, vi_b, sat_b, tie_b;
    logic [1:0] winner_b;
    logic [3:0] total_b;

    always #5 clk = ~clk;

    voting_machine_multi #(.NUM_CAND(NC), .CNT_W(8), .HOLD_CYCLES(HOLD)) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .button(button), .led(led_a),
        .vote_valid(vv_a), .vote_invalid(vi_a), .sat(sat_a),
        .winner(winner_a), .tie(tie_a), .total(total_a)
    );

    voting_machine_multi #(.NUM_CAND(NC), .CNT_W(2), .HOLD_CYCLES(HOLD)) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .button(button), .led(led_b),
        .vote_valid(vv_b), .vote_invalid(vi_b), .sat(sat_b),
        .winner(winner_b), .tie(tie_b), .total(total_b)
    );

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    // observed pulse counts (cycles high), sampled just after each edge
    int nvv_a = 0, nvv_b = 0, nvi_a = 0, nvi_b = 0;
    always @(posedge clk) begin
        #1;
        if (vv_a === 1'b1) nvv_a++;
        if (vv_b === 1'b1) nvv_b++;
        if (vi_a === 1'b1) nvi_a++;
        if (vi_b === 1'b1) nvi_b++;
    end

    // reference model: tallies per instance and expected event counts
    int m_a[NC];
    int m_b[NC];
    int exp_vv_a = 0, exp_vv_b = 0, exp_vi = 0;
    int exp_sat_a = 0, exp_sat_b = 0;

    int         kind, k, len;
    logic [3:0] pat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) begin
            npass++;
        end else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_reset();
        for (int i = 0; i < NC; i++) begin
            m_a[i] = 0;
            m_b[i] = 0;
        end
        exp_sat_a = 0;
        exp_sat_b = 0;
    endtask

    task automatic m_vote(input int c);
        if (m_a[c] < MAXA) begin m_a[c]++; exp_vv_a++; end else exp_sat_a = 1;
        if (m_b[c] < MAXB) begin m_b[c]++; exp_vv_b++; end else exp_sat_b = 1;
    endtask

    function automatic int sum_of(input int t[NC]);
        int s = 0;
        foreach (t[i]) s += t[i];
        return s;
    endfunction

    function automatic int max_of(input int t[NC]);
        int m = 0;
        foreach (t[i]) if (t[i] > m) m = t[i];
        return m;
    endfunction

    function automatic int leader(input int t[NC]);
        int m = max_of(t);
        for (int i = 0; i < NC; i++) if (t[i] == m) return i;
        return 0;
    endfunction

    function automatic int tied(input int t[NC]);
        int m = max_of(t);
        int c = 0;
        foreach (t[i]) if (t[i] == m) c++;
        return (m > 0 && c >= 2) ? 1 : 0;
    endfunction

    function automatic int lowest(input logic [3:0] p);
        for (int i = 0; i < NC; i++) if (p[i]) return i;
        return 0;
    endfunction

    // compare every externally visible result against the model
    task automatic check_all(input string tag);
        chk({tag, " total_a"},  total_a,  sum_of(m_a));
        chk({tag, " total_b"},  total_b,  sum_of(m_b));
        chk({tag, " nvalid_a"}, nvv_a,    exp_vv_a);
        chk({tag, " nvalid_b"}, nvv_b,    exp_vv_b);
        chk({tag, " ninval_a"}, nvi_a,    exp_vi);
        chk({tag, " ninval_b"}, nvi_b,    exp_vi);
        chk({tag, " sat_a"},    sat_a,    exp_sat_a);
        chk({tag, " sat_b"},    sat_b,    exp_sat_b);
        chk({tag, " winner_a"}, winner_a, leader(m_a));
        chk({tag, " tie_a"},    tie_a,    tied(m_a));
        chk({tag, " winner_b"}, winner_b, leader(m_b));
        chk({tag, " tie_b"},    tie_b,    tied(m_b));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " led_a"},    led_a,    0);
        chk({tag, " led_b"},    led_b,    0);
        chk({tag, " total_a"},  total_a,  0);
        chk({tag, " total_b"},  total_b,  0);
        chk({tag, " valid_a"},  vv_a,     0);
        chk({tag, " inval_a"},  vi_a,     0);
        chk({tag, " sat_a"},    sat_a,    0);
        chk({tag, " sat_b"},    sat_b,    0);
        chk({tag, " winner_a"}, winner_a, 0);
        chk({tag, " tie_a"},    tie_a,    0);
    endtask

    // a press of pattern p for n sampled cycles, then release and settle
    task automatic press(input logic [3:0] p, input int n);
        button = p;
        cyc(n);
        button = '0;
        cyc(2);
        if ($countones(p) == 1 && n >= HOLD) m_vote(lowest(p));
        else if ($countones(p) >= 2) exp_vi++;
    endtask

    // enter result mode with pattern p, hold n cycles, release, return to voting
    task automatic disp_tail(input logic [3:0] p, input int n);
        mode   = 1'b1;
        button = p;
        cyc(n);
        chk("disp led_a", led_a, m_a[lowest(p)]);
        chk("disp led_b", led_b, m_b[lowest(p)]);
        button = '0;
        cyc(1);
        chk("disp hold led_a", led_a, m_a[lowest(p)]);
        mode = 1'b0;
        cyc(1);
        chk("disp off led_a", led_a, 0);
        cyc(1);
    endtask

    task automatic mode_abort(input int c, input int n, input int dn);
        button = 4'(1 << c);
        cyc(n);
        disp_tail(4'(1 << c), dn);
    endtask

    task automatic extra_abort(input int c, input int n, input int e);
        button = 4'(1 << c);
        cyc(n);
        button = button | 4'(1 << e);
        cyc(2);
        button = '0;
        cyc(2);
        exp_vi++;
    endtask

    initial begin
        m_reset();

        // T1: reset with buttons active
        rst = 1'b0; button = 4'b1111; mode = 1'b0;
        cyc(3);
        check_zero("T1");
        rst = 1'b1; button = '0;
        cyc(2);

        // T2: 9-cycle hold is rejected, long hold gives exactly one vote at cycle HOLD
        press(4'b0001, 9);
        check_all("T2 short");
        button = 4'b0001;
        cyc(HOLD - 1);
        chk("T2 pre total_a", total_a, 0);
        chk("T2 pre valid_a", vv_a, 0);
        cyc(1);
        chk("T2 lat valid_a", vv_a, 1);
        chk("T2 lat total_a", total_a, 1);
        cyc(20 - HOLD);
        button = '0;
        cyc(2);
        m_vote(0);
        check_all("T2 long");

        // T3: multi-press rejected, then a clean exact-length press counts
        press(4'b0110, 4);
        check_all("T3 multi");
        press(4'b0100, HOLD);
        check_all("T3 release");

        // T4: mode change mid-hold aborts; display shows tally and holds on release
        mode_abort(0, 5, 1);
        check_all("T4 abort");
        extra_abort(2, 6, 0);
        check_all("T4 extra");

        // reset in the middle of a hold wipes everything and counts nothing
        button = 4'b0100;
        cyc(5);
        rst = 1'b0;
        cyc(2);
        m_reset();
        check_zero("RST mid");
        rst = 1'b1; button = '0;
        cyc(2);
        check_all("RST after");

        // T5: tie between c0 and c3, then c3 pulls ahead one cycle after its tally
        press(4'b0001, HOLD); press(4'b0001, HOLD);
        press(4'b1000, HOLD); press(4'b1000, HOLD);
        chk("T5 winner", winner_a, 0);
        chk("T5 tie", tie_a, 1);
        check_all("T5 tie");
        button = 4'b1000;
        cyc(HOLD);
        chk("T5 lag winner", winner_a, 0);
        chk("T5 lag tie", tie_a, 1);
        cyc(1);
        chk("T5 new winner", winner_a, 3);
        chk("T5 new tie", tie_a, 0);
        button = '0;
        cyc(2);
        m_vote(3);
        check_all("T5 change");

        // T6: four votes for c1 saturate the 2-bit instance
        for (int i = 0; i < 3; i++) press(4'b0010, HOLD);
        chk("T6 sat_b early", sat_b, 0);
        press(4'b0010, HOLD);
        chk("T6 sat_b", sat_b, 1);
        check_all("T6");
        cyc(5);
        chk("T6 sat_b sticky", sat_b, 1);

        // randomised sessions
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 3);
            k    = $urandom_range(0, NC - 1);
            len  = $urandom_range(1, 14);
            case (kind)
                0: press(4'(1 << k), len);
                1: begin
                    pat = 4'($urandom_range(0, 15));
                    if ($countones(pat) < 2) pat = 4'b1011;
                    press(pat, len);
                end
                2: extra_abort(k, $urandom_range(1, HOLD - 1), (k + 1 + $urandom_range(0, 2)) % NC);
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        mode_abort(k, $urandom_range(1, HOLD - 1), $urandom_range(1, 15));
                    end else begin
                        pat = 4'($urandom_range(1, 15));
                        disp_tail(pat, $urandom_range(1, 15));
                    end
                end
            endcase
            check_all($sformatf("R%0d", it));
        end

        // final reset clears the sticky flag and all results
        rst = 1'b0;
        cyc(2);
        m_reset();
        check_zero("final");
        rst = 1'b1;
        cyc(1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
`default_nettype wire
